// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder controller.
// master: requester side (drives start/operands); slave: the controller.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovfl;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovfl
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovfl
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced LSB-first over
// WIDTH cycles with carry recirculation and a start/busy/done handshake.
// Optional subtract support is compiled in with `define SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovfl_q, ovfl_d;

    logic             fa_sum_c;
    logic             fa_cout_c;
    logic [WIDTH-1:0] op_b_c;
    logic             op_c_c;

    // Operand B and carry-in as loaded on the accepting edge.
`ifdef SERIAL_ADD_SUB_EN
    assign op_b_c = bus.sub ? ~bus.b : bus.b;
    assign op_c_c = bus.sub ? 1'b1   : bus.cin;
`else
    logic unused_sub_c;
    assign op_b_c       = bus.b;
    assign op_c_c       = bus.cin;
    assign unused_sub_c = bus.sub;
`endif

    // The single full-adder cell shared by every bit position.
    serial_add_fa u_fa (
        .a_i      (sa_q[0]),
        .b_i      (sb_q[0]),
        .c_i      (c_q),
        .sum_c_o  (fa_sum_c),
        .cout_c_o (fa_cout_c)
    );

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovfl_d  = ovfl_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = op_b_c;
                    c_d     = op_c_c;
                    cnt_d   = CNT_W'(0);
                    res_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                res_d = {fa_sum_c, res_q[WIDTH-1:1]};
                c_d   = fa_cout_c;
                if (cnt_q == CNT_LAST) begin
                    // Last bit: capture the word; overflow is carry-in XOR carry-out of the MSB.
                    sum_d   = {fa_sum_c, res_q[WIDTH-1:1]};
                    cout_d  = fa_cout_c;
                    ovfl_d  = c_q ^ fa_cout_c;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q   <= '0;
            sb_q   <= '0;
            res_q  <= '0;
            c_q    <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovfl_q <= 1'b0;
        end else begin
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            res_q  <= res_d;
            c_q    <= c_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovfl_q <= ovfl_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovfl = ovfl_q;
endmodule

// One-bit full-adder cell.
module serial_add_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_c_o,
    output logic cout_c_o
);
    assign sum_c_o  = a_i ^ b_i ^ c_i;
    assign cout_c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed-vector bench for serial_add_ctrl (WIDTH=8).
// Define SERIAL_ADD_SUB_EN for both bench and RTL to exercise subtraction.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [7:0] last_sum;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report a mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.ovfl, bus.cout, bus.done, bus.busy, bus.sum});
    endfunction

    function automatic logic [31:0] hs();
        return 32'({bus.busy, bus.done});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation with latency, hold and result checks.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub,
                          input logic [7:0] es, input logic ec, input logic eo);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.sub   = sub;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.cin   = ~cin;
        chk({tag, "_accept"}, hs(), 32'h2);
        for (int i = 1; i <= W; i++) begin
            step();
            if (i < W) begin
                chk({tag, "_run"}, hs(), 32'h2);
                if (i == W / 2) chk({tag, "_hold"}, 32'(bus.sum), 32'(last_sum));
            end
        end
        chk({tag, "_done"}, hs(), 32'h1);
        chk({tag, "_sum"},  32'(bus.sum),  32'(es));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        chk({tag, "_ovfl"}, 32'(bus.ovfl), 32'(eo));
        step();
        chk({tag, "_idle"}, hs(), 32'h0);
        chk({tag, "_keep"}, 32'(bus.sum), 32'(es));
        last_sum = es;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        last_sum  = 8'h00;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        #2 rst_n = 1'b0;
        step();
        step();
        chk("reset_outs", outs(), 32'h0);
        rst_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_outs", outs(), 32'h0);
        end

        // Basic additions and carry/overflow boundaries.
        run_op("add_3c_05", 8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add_7f_00c", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);

        // Start while busy ignored; held start accepted two edges after done.
        bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("busy_ign_accept", hs(), 32'h2);
        step();
        step();
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
        for (int i = 3; i < W; i++) begin
            step();
            chk("busy_ign_run", hs(), 32'h2);
            if (i == 5) chk("busy_ign_hold", 32'(bus.sum), 32'h80);
        end
        step();
        chk("busy_ign_done", hs(), 32'h1);
        chk("busy_ign_sum",  32'(bus.sum),  32'h30);
        chk("busy_ign_cout", 32'(bus.cout), 32'h0);
        chk("busy_ign_ovfl", 32'(bus.ovfl), 32'h0);
        step();
        chk("held_start_idle", hs(), 32'h0);
        step();
        chk("held_start_accept", hs(), 32'h2);
        bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
        for (int i = 1; i < W; i++) begin
            step();
        end
        chk("held_run_last", hs(), 32'h2);
        chk("held_hold", 32'(bus.sum), 32'h30);
        step();
        chk("held_done", hs(), 32'h1);
        chk("held_sum",  32'(bus.sum),  32'hFF);
        chk("held_cout", 32'(bus.cout), 32'h0);
        chk("held_ovfl", 32'(bus.ovfl), 32'h0);
        step();
        chk("held_idle", hs(), 32'h0);

        // Reset mid-operation.
        bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 1; i <= 4; i++) step();
        chk("abort_busy", hs(), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("abort_outs", outs(), 32'h0);
        step();
        chk("abort_hold1", outs(), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            step();
            chk("abort_no_done", outs(), 32'h0);
        end
        last_sum = 8'h00;
        run_op("add_01_01", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

        // Subtract request: active only when the feature is compiled in.
`ifdef SERIAL_ADD_SUB_EN
        run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
`else
        run_op("nosub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
